// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the SYS_TOP command sequencer: opcodes, FSM encoding, operand addresses.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WR_ADDR  = 4'd1;
  localparam logic [3:0] ST_WR_DATA  = 4'd2;
  localparam logic [3:0] ST_RD_ADDR  = 4'd3;
  localparam logic [3:0] ST_RD_WAIT  = 4'd4;
  localparam logic [3:0] ST_OP_A     = 4'd5;
  localparam logic [3:0] ST_OP_B     = 4'd6;
  localparam logic [3:0] ST_ALU_FUN  = 4'd7;
  localparam logic [3:0] ST_ALU_WAIT = 4'd8;
  localparam logic [3:0] ST_TX_LSB   = 4'd9;
  localparam logic [3:0] ST_TX_MSB   = 4'd10;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  // States in which the sequencer is waiting for the next byte of a frame.
  function automatic logic is_frame_state(input logic [3:0] s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_OP_A)    || (s == ST_OP_B)    || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_cmd_timeout.sv
// Inter-byte watchdog: counts idle cycles while a frame is open, pulses expired at the limit.
module sys_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || !en)
      cnt <= '0;
    else if (cnt != CW'(TIMEOUT_CYC))
      cnt <= cnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYC-th silent cycle; a byte arriving that cycle wins.
  assign expired = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/sys_cmd_sequencer.sv
// UART frame decoder driving the RF, the ALU and the TX FIFO in the REF_CLK domain.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module sys_cmd_sequencer
  import sys_ctrl_pkg::*;
#(
  parameter int Data_width  = 8,
  parameter int Addr_width  = 4,
  parameter int ALU_FUN_W   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [Data_width-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [Addr_width-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [Data_width-1:0]   RF_WrData,
  input  logic [Data_width-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  output logic [ALU_FUN_W-1:0]    ALU_FUN,
  output logic                    ALU_EN,
  output logic                    CLK_GATE_EN,
  input  logic [2*Data_width-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [Data_width-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    FIFO_FULL,
  output logic                    CMD_ERR
);

  logic [3:0]              state;
  logic [Addr_width-1:0]   wr_addr;
  logic [2*Data_width-1:0] result;
  logic                    single_byte;
  logic                    timeout_hit;

`ifdef CMD_TIMEOUT_EN
  sys_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (CLK),
    .rst     (RST),
    .clr     (RX_D_VLD),
    .en      (is_frame_state(state)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      wr_addr     <= '0;
      result      <= '0;
      single_byte <= 1'b0;
      RF_Address  <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_WrData   <= '0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;

      if (timeout_hit) begin
        CMD_ERR     <= 1'b1;
        CLK_GATE_EN <= 1'b0;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (RX_D_VLD) begin
            case (RX_P_DATA)
              CMD_RF_WR:   state <= ST_WR_ADDR;
              CMD_RF_RD:   state <= ST_RD_ADDR;
              CMD_ALU_OP:  state <= ST_OP_A;
              CMD_ALU_NOP: begin
                state       <= ST_ALU_FUN;
                CLK_GATE_EN <= 1'b1;
              end
              default:     CMD_ERR <= 1'b1;
            endcase
          end

          ST_WR_ADDR: if (RX_D_VLD) begin
            wr_addr <= RX_P_DATA[Addr_width-1:0];
            state   <= ST_WR_DATA;
          end

          ST_WR_DATA: if (RX_D_VLD) begin
            RF_Address <= wr_addr;
            RF_WrData  <= RX_P_DATA;
            RF_WrEn    <= 1'b1;
            state      <= ST_IDLE;
          end

          ST_RD_ADDR: if (RX_D_VLD) begin
            RF_Address <= RX_P_DATA[Addr_width-1:0];
            RF_RdEn    <= 1'b1;
            state      <= ST_RD_WAIT;
          end

          ST_RD_WAIT: if (RF_RdData_VLD) begin
            result      <= {{Data_width{1'b0}}, RF_RdData};
            single_byte <= 1'b1;
            state       <= ST_TX_LSB;
          end

          ST_OP_A: if (RX_D_VLD) begin
            RF_Address <= Addr_width'(OPA_ADDR);
            RF_WrData  <= RX_P_DATA;
            RF_WrEn    <= 1'b1;
            state      <= ST_OP_B;
          end

          ST_OP_B: if (RX_D_VLD) begin
            RF_Address  <= Addr_width'(OPB_ADDR);
            RF_WrData   <= RX_P_DATA;
            RF_WrEn     <= 1'b1;
            CLK_GATE_EN <= 1'b1;
            state       <= ST_ALU_FUN;
          end

          ST_ALU_FUN: if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[ALU_FUN_W-1:0];
            ALU_EN  <= 1'b1;
            state   <= ST_ALU_WAIT;
          end

          ST_ALU_WAIT: if (ALU_OUT_VLD) begin
            result      <= ALU_OUT;
            single_byte <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            state       <= ST_TX_LSB;
          end

          // A full FIFO stalls the response; the byte is retried every cycle.
          ST_TX_LSB: if (!FIFO_FULL) begin
            TX_P_DATA <= result[Data_width-1:0];
            TX_D_VLD  <= 1'b1;
            state     <= single_byte ? ST_IDLE : ST_TX_MSB;
          end

          ST_TX_MSB: if (!FIFO_FULL) begin
            TX_P_DATA <= result[2*Data_width-1:Data_width];
            TX_D_VLD  <= 1'b1;
            state     <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_cmd_sequencer.sv
// Directed scoreboard bench for sys_cmd_sequencer with RF and ALU responder models.
module tb_sys_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_Address;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        FIFO_FULL;
  logic        CMD_ERR;

  sys_cmd_sequencer dut (
    .CLK (CLK), .RST (RST),
    .RX_P_DATA (RX_P_DATA), .RX_D_VLD (RX_D_VLD),
    .RF_Address (RF_Address), .RF_WrEn (RF_WrEn), .RF_RdEn (RF_RdEn),
    .RF_WrData (RF_WrData), .RF_RdData (RF_RdData), .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_FUN (ALU_FUN), .ALU_EN (ALU_EN), .CLK_GATE_EN (CLK_GATE_EN),
    .ALU_OUT (ALU_OUT), .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_P_DATA (TX_P_DATA), .TX_D_VLD (TX_D_VLD), .FIFO_FULL (FIFO_FULL),
    .CMD_ERR (CMD_ERR)
  );

  always #5 CLK = ~CLK;

  logic [11:0] wr_q [$];
  logic [3:0]  rd_q [$];
  logic [3:0]  fun_q [$];
  logic [7:0]  tx_q [$];

  int checks = 0, failures = 0, err_seen = 0, exp_err = 0;
  bit full_window = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0]  rf_mem [16];
  logic [15:0] alu_result = '0;
  logic [3:0]  rd_cap;
  logic [11:0] e_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next expectation queued by the stimulus.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (RF_WrEn === 1'b1) begin
        rf_mem[RF_Address] = RF_WrData;
        if (wr_q.size() == 0) chk("rf_wr_unexpected", {RF_Address, RF_WrData}, 32'hFFFF_FFFF);
        else begin e_wr = wr_q.pop_front(); chk("rf_wr", {RF_Address, RF_WrData}, e_wr); end
      end
      if (RF_RdEn === 1'b1) begin
        if (rd_q.size() == 0) chk("rf_rd_unexpected", RF_Address, 32'hFFFF_FFFF);
        else chk("rf_rd_addr", RF_Address, rd_q.pop_front());
      end
      if (ALU_EN === 1'b1) begin
        chk("gate_at_alu_en", CLK_GATE_EN, 1);
        if (fun_q.size() == 0) chk("alu_en_unexpected", ALU_FUN, 32'hFFFF_FFFF);
        else chk("alu_fun", ALU_FUN, fun_q.pop_front());
      end
      if (TX_D_VLD === 1'b1) begin
        if (full_window) chk("tx_while_full", 1, 0);
        if (tx_q.size() == 0) chk("tx_unexpected", TX_P_DATA, 32'hFFFF_FFFF);
        else chk("tx_data", TX_P_DATA, tx_q.pop_front());
      end
      if (CMD_ERR === 1'b1) begin
        err_seen++;
        if (prev_err) chk("cmd_err_width", 2, 1);
      end
      prev_err = CMD_ERR;
    end
  end

  always begin
    @(posedge CLK);
    if (RF_RdEn === 1'b1) begin
      rd_cap = RF_Address;
      repeat (2) @(posedge CLK);
      #1 RF_RdData = rf_mem[rd_cap]; RF_RdData_VLD = 1'b1;
      @(posedge CLK);
      #1 RF_RdData_VLD = 1'b0;
    end
  end

  always begin
    @(posedge CLK);
    if (ALU_EN === 1'b1) begin
      repeat (6) @(posedge CLK);
      #1 ALU_OUT = alu_result; ALU_OUT_VLD = 1'b1;
      @(posedge CLK);
      #1 ALU_OUT_VLD = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size()) != 0 && n < 300) begin
      @(posedge CLK); n++;
    end
    chk(tag, wr_q.size() + rd_q.size() + fun_q.size() + tx_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD, CMD_ERR, CLK_GATE_EN}, 0);
    chk({tag, "_buses"}, {RF_Address, RF_WrData, ALU_FUN, TX_P_DATA}, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = '0;
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RdData = '0; RF_RdData_VLD = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
    repeat (3) @(posedge CLK);
    #1 chk_all_zero("reset");
    @(negedge CLK) RST = 1'b0;

    // RF write
    wr_q.push_back({4'h5, 8'hD6});
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'hD6);
    chk("wr_latency", RF_WrEn, 1);
    drain("t1_drain");

    // RF read, single-byte response
    rd_q.push_back(4'h5); tx_q.push_back(8'hD6);
    send_byte(8'hBB); send_byte(8'h05);
    chk("rd_latency", RF_RdEn, 1);
    drain("t2_drain");

    // ALU with operands
    wr_q.push_back({4'h0, 8'h0C}); wr_q.push_back({4'h1, 8'h05});
    fun_q.push_back(4'h2); tx_q.push_back(8'h3C); tx_q.push_back(8'h00);
    alu_result = 16'h003C;
    chk("gate_idle", CLK_GATE_EN, 0);
    send_byte(8'hCC);
    chk("gate_op_a", CLK_GATE_EN, 0);
    send_byte(8'h0C); send_byte(8'h05); send_byte(8'h02);
    drain("t3_drain");
    chk("gate_after_alu", CLK_GATE_EN, 0);

    // Bad opcode then a normal frame
    send_byte(8'h5A); exp_err++;
    chk("cmd_err_pulse", CMD_ERR, 1);
    @(posedge CLK); #1;
    chk("cmd_err_clear", CMD_ERR, 0);
    chk("err_count_bad_op", err_seen, exp_err);
    wr_q.push_back({4'h1, 8'hFF});
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    drain("t4_drain");

    // FIFO back-pressure on a no-operand ALU response; stray byte in ALU_WAIT dropped
    fun_q.push_back(4'h7); tx_q.push_back(8'h34); tx_q.push_back(8'h12);
    alu_result = 16'h1234;
    send_byte(8'hDD); send_byte(8'h07);
    FIFO_FULL = 1'b1; full_window = 1'b1;
    send_byte(8'h77);
    repeat (20) @(posedge CLK);
    #1 chk("tx_held_count", tx_q.size(), 2);
    full_window = 1'b0; FIFO_FULL = 1'b0;
    drain("t5_drain");
    chk("err_count_dropped", err_seen, exp_err);

    // Reset in OP_B discards the frame
    wr_q.push_back({4'h0, 8'h11});
    send_byte(8'hCC); send_byte(8'h11);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 chk_all_zero("mid_reset");
    RST = 1'b0;
    wr_q.push_back({4'h2, 8'h33});
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h33);
    drain("t6_drain");
    chk("gate_after_reset", CLK_GATE_EN, 0);

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAA);
    repeat (1024 + 5) @(posedge CLK);
    #1 exp_err++;
    chk("err_count_timeout", err_seen, exp_err);
`endif

    chk("err_count_final", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
